// File: rtl/divisible_n_pkg.sv
// Shared definitions for the divisibility scheduler slice:
// FSM state encoding, ceil-log2 helper and derived port widths.
package divisible_n_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int v);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Remainder width for divisor n.
    function automatic int rw_of(input int n);
        return clog2(n);
    endfunction

    // Requester-id width; at least one bit.
    function automatic int sw_of(input int nreq);
        return (clog2(nreq) < 1) ? 1 : clog2(nreq);
    endfunction

    // Bit-counter width for a w-bit word; at least one bit.
    function automatic int cw_of(input int w);
        return (clog2(w) < 1) ? 1 : clog2(w);
    endfunction

endpackage

// File: rtl/div_rem_serial.sv
// Bit-serial mod-N remainder engine, fed MSB-first.
// Ports: clk, rst (async active-low), clr (zero r), en (absorb bit_in), r (remainder).
module div_rem_serial
    import divisible_n_pkg::*;
#(
    parameter int N = 5,
    localparam int RW = rw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [RW-1:0] r
);

    localparam logic [RW:0] NN = (RW + 1)'(N);

    logic [RW:0]   dbl;
    logic [RW-1:0] nxt;

    // r < N, so 2r+bit < 2N and a single subtract brings it back in range.
    always_comb begin
        dbl = {r, bit_in};
        nxt = RW'((dbl >= NN) ? (dbl - NN) : dbl);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else if (clr) begin
            r <= '0;
        end else if (en) begin
            r <= nxt;
        end
    end

endmodule

// File: rtl/divisible_n_sched.sv
// Round-robin front end sharing one serial mod-N engine among NREQ
// parallel requesters.
// Ports: clk, rst (async active-low); req/data (requester side);
// ack (one-hot grant pulse), busy, done (result pulse), div_ok, rem and src
// (result, held between done pulses).
module divisible_n_sched
    import divisible_n_pkg::*;
#(
    parameter int N    = 5,
    parameter int W    = 8,
    parameter int NREQ = 2,
    localparam int RW  = rw_of(N),
    localparam int SW  = sw_of(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              done,
    output logic              div_ok,
    output logic [RW-1:0]     rem,
    output logic [SW-1:0]     src
);

    localparam int CW = cw_of(W);

    state_t         state;
    logic [SW-1:0]  ptr;
    logic [SW-1:0]  gnt_id;
    logic [W-1:0]   shreg;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  r;

    logic           found;
    logic [SW-1:0]  gnt;
    logic [SW-1:0]  nxt_ptr;
    int             scan;
    logic           eng_clr;
    logic           eng_en;

    // Circular search for the first asserted request at or after ptr.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        scan  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!found && req[scan]) begin
                found = 1'b1;
                gnt   = SW'(scan);
            end
        end
    end

    always_comb begin
        if (int'(gnt) == NREQ - 1) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = gnt + 1'b1;
        end
    end

    assign eng_clr = (state == IDLE) && found;
    assign eng_en  = (state == SHIFT);

    div_rem_serial #(
        .N (N)
    ) u_rem (
        .clk    (clk),
        .rst    (rst),
        .clr    (eng_clr),
        .en     (eng_en),
        .bit_in (shreg[W-1]),
        .r      (r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
            shreg  <= '0;
            cnt    <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div_ok <= 1'b0;
            rem    <= '0;
            src    <= '0;
        end else begin
            ack  <= '0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        shreg  <= data[int'(gnt)*W +: W];
                        cnt    <= CW'(W - 1);
                        gnt_id <= gnt;
                        ack    <= NREQ'(1) << gnt;
                        ptr    <= nxt_ptr;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    cnt   <= cnt - 1'b1;
                    // cnt==0 marks the W-th bit being absorbed this edge.
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rem    <= r;
                    div_ok <= (r == '0);
                    src    <= gnt_id;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
